// File: rtl/mem_stage_lsu_pkg.sv
// cpu_pkg: shared constants, state enum and store-lane helpers for the MEM-stage LSU.
package cpu_pkg;
  localparam int IT_LOAD  = 0;
  localparam int IT_STORE = 1;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  typedef enum logic [1:0] {IDLE, REQ, RDW, WB} state_e;
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] o);
    return f3[1:0] == 2'b00 ? 4'b0001 << o : f3[1:0] == 2'b01 ? 4'b0011 << {o[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    return f3[1:0] == 2'b00 ? {4{wd[7:0]}} : f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] o);
    return (f3[1:0] == 2'b01 && o[0]) || (f3[1:0] == 2'b10 && o != 2'b00);
  endfunction
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory request/response channel between the LSU and memory.
interface mem_stage_lsu_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  modport master(output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
                 input Mem_Req_Ready, Read_data, Read_data_Valid);
  modport slave(input Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
                output Mem_Req_Ready, Read_data, Read_data_Valid);
endinterface

// File: rtl/mem_stage_lsu_load_extract.sv
// load_extract: shifts the response word down to the addressed lane and sign/zero extends it.
module load_extract
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] raw,
  output logic [31:0] result
);
  logic [31:0] sh;
  assign sh = raw >> {offset, 3'b000};
  assign result = funct3 == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
                  funct3 == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
                  funct3 == F3_LBU ? {24'b0, sh[7:0]} :
                  funct3 == F3_LHU ? {16'b0, sh[15:0]} : sh;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit between EX/MEM, data memory and MEM/WB.
// Define MEM_MISALIGN_CHECK_EN to bypass memory for misaligned H/W accesses and flag wb_misalign.
module mem_stage_lsu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [7:0]  in_instr_type,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_ex_result,
  input  logic [31:0] in_write_data,
  input  logic [4:0]  in_rd,
  mem_stage_lsu_if.master mem,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_wen
`ifdef MEM_MISALIGN_CHECK_EN
  ,output logic       wb_misalign
`endif
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, ld_data;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  strb_q, strb_d;
  logic        ld_q, ld_d, wen_q, wen_d, mis_q, mis_d;
  logic        ld_in, st_in, mis, accept, unused_type;
  assign ld_in = in_instr_type[IT_LOAD];
  assign st_in = in_instr_type[IT_STORE];
  assign unused_type = ^in_instr_type;
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = (ld_in | st_in) & misaligned(in_funct3, in_ex_result[1:0]);
  assign wb_misalign = mis_q;
`else
  assign mis = 1'b0;
`endif
  assign in_ready = state_q == IDLE || (state_q == WB && wb_ready);
  assign accept   = in_valid & in_ready;
  load_extract u_extract (.funct3(f3_q), .offset(addr_q[1:0]), .raw(mem.Read_data), .result(ld_data));
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    ld_d    = ld_q;
    wen_d   = wen_q;
    data_d  = data_q;
    mis_d   = mis_q;
    if (accept) begin
      pc_d    = in_pc;
      rd_d    = in_rd;
      f3_d    = in_funct3;
      addr_d  = in_ex_result;
      wdata_d = store_data(in_funct3, in_write_data);
      strb_d  = store_strb(in_funct3, in_ex_result[1:0]);
      ld_d    = ld_in & ~st_in;
      wen_d   = ~st_in & (in_rd != 5'd0);
      data_d  = in_ex_result;
      mis_d   = mis;
      state_d = (ld_in | st_in) & ~mis ? REQ : WB;
    end else if (state_q == REQ && mem.Mem_Req_Ready) begin
      state_d = ld_q ? RDW : WB;
    end else if (state_q == RDW && mem.Read_data_Valid) begin
      data_d  = ld_data;
      state_d = WB;
    end else if (state_q == WB && wb_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      ld_q    <= 1'b0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      ld_q    <= ld_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
    end
  end
  assign mem.Address         = {addr_q[31:2], 2'b00};
  assign mem.Write_data      = wdata_q;
  assign mem.Write_strb      = strb_q;
  assign mem.MemRead         = state_q == REQ && ld_q;
  assign mem.MemWrite        = state_q == REQ && !ld_q;
  assign mem.Read_data_Ready = state_q == RDW;
  assign wb_valid = state_q == WB;
  assign wb_pc    = pc_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign wb_wen   = wen_q & ~mis_q;
endmodule
